// File: rtl/seq_pkg.sv
// Shared types and stage/state helpers for the CNN stage sequencer.
// Stage k owns state pair RUN<k>/GAP<k>; the helpers map between the two views.
package seq_pkg;

  localparam int NUM_STAGES = 4;

  typedef logic [1:0] stage_idx_t;

  typedef enum logic [3:0] {
    IDLE,
    RUN0,
    RUN1,
    RUN2,
    RUN3,
    GAP0,
    GAP1,
    GAP2,
    GAP3,
    FIN,
    ERR
  } state_t;

  function automatic logic is_run(state_t s);
    return (s == RUN0) || (s == RUN1) || (s == RUN2) || (s == RUN3);
  endfunction

  function automatic logic is_gap(state_t s);
    return (s == GAP0) || (s == GAP1) || (s == GAP2) || (s == GAP3);
  endfunction

  function automatic stage_idx_t stage_of(state_t s);
    stage_idx_t k;
    case (s)
      RUN1, GAP1: k = 2'd1;
      RUN2, GAP2: k = 2'd2;
      RUN3, GAP3: k = 2'd3;
      default:    k = 2'd0;
    endcase
    return k;
  endfunction

  function automatic state_t run_state(stage_idx_t k);
    state_t s;
    case (k)
      2'd1:    s = RUN1;
      2'd2:    s = RUN2;
      2'd3:    s = RUN3;
      default: s = RUN0;
    endcase
    return s;
  endfunction

  function automatic state_t gap_state(stage_idx_t k);
    state_t s;
    case (k)
      2'd1:    s = GAP1;
      2'd2:    s = GAP2;
      2'd3:    s = GAP3;
      default: s = GAP0;
    endcase
    return s;
  endfunction

  function automatic logic [NUM_STAGES-1:0] stage_onehot(stage_idx_t k);
    logic [NUM_STAGES-1:0] one;
    one = NUM_STAGES'(1);
    return one << k;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle watchdog: counts enabled cycles from a clear, flags the TIMEOUT-th cycle.
// Terminal flag is combinational from the count register; the count parks at its last value.
module stage_watchdog #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Steps conv1 -> pool1 -> conv2 -> fc per frame via level timer requests; requests rise
// the cycle after start is sampled. No backpressure: abort wins over every other input.
module stage_sequencer #(
  parameter int NUM_FRAMES = 1,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 4095
) (
  input  logic       S_AXIS_ACLK,
  input  logic       S_AXIS_ARESET,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] tmr_done,
  output logic [3:0] tmr_req,
  output logic [3:0] stage_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_stage,
  output logic [7:0] frame_cnt
);

  import seq_pkg::*;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [7:0] FRAMES = 8'(NUM_FRAMES);

  state_t state, next_state;
  stage_idx_t cur_stage;
  logic [GW-1:0] gap_cnt;
  logic gap_last;
  logic wd_tc;
  logic [7:0] frame_nxt;
  logic start_run;
  logic frame_step;

  assign cur_stage = stage_of(state);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign frame_nxt = (frame_cnt == 8'hFF) ? 8'hFF : frame_cnt + 8'd1;

  stage_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (S_AXIS_ACLK),
    .rst   (S_AXIS_ARESET),
    .clear (!is_run(state)),
    .enable(is_run(state)),
    .tc    (wd_tc)
  );

  always_comb begin
    next_state = state;
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start && !abort) next_state = RUN0;
        end
        RUN0, RUN1, RUN2, RUN3: begin
          // A timer expiring on the watchdog terminal cycle still counts as success.
          if (tmr_done[cur_stage]) next_state = gap_state(cur_stage);
          else if (wd_tc)          next_state = ERR;
        end
        GAP0, GAP1, GAP2, GAP3: begin
          if (gap_last) begin
            if (cur_stage != 2'd3)       next_state = run_state(cur_stage + 2'd1);
            else if (frame_nxt < FRAMES) next_state = RUN0;
            else                         next_state = FIN;
          end
        end
        FIN:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign start_run  = (next_state == RUN0) && ((state == IDLE) || (state == ERR));
  assign frame_step = (state == GAP3) && gap_last && !abort;

  // Outputs are decoded from next_state so they are registered yet line up with the state.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      tmr_req   <= '0;
      stage_en  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_stage <= '0;
      frame_cnt <= '0;
    end else begin
      state   <= next_state;
      gap_cnt <= is_gap(state) ? gap_cnt + 1'b1 : '0;

      if (is_run(next_state)) begin
        tmr_req  <= stage_onehot(stage_of(next_state));
        stage_en <= stage_onehot(stage_of(next_state));
      end else begin
        tmr_req  <= '0;
        stage_en <= '0;
      end

      busy <= !((next_state == IDLE) || (next_state == ERR) || (next_state == FIN));
      done <= (next_state == FIN);
      err  <= (next_state == ERR);

      if ((next_state == ERR) && (state != ERR)) err_stage <= cur_stage;
      else if (next_state != ERR)                err_stage <= '0;

      if (start_run)       frame_cnt <= '0;
      else if (frame_step) frame_cnt <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench: two sequencer instances driven by a threshold-based timer model.
module tb_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, abort_a, busy_a, done_a, err_a;
  logic [3:0] tdone_a, req_a, en_a, stray_a;
  logic [1:0] estg_a;
  logic [7:0] fcnt_a;
  logic start_b, abort_b, busy_b, done_b, err_b;
  logic [3:0] tdone_b, req_b, en_b;
  logic [1:0] estg_b;
  logic [7:0] fcnt_b;

  int checks = 0;
  int errors = 0;

  stage_sequencer #(.NUM_FRAMES(1), .GAP_CYCLES(1), .TIMEOUT(4095)) dut_a (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start(start_a), .abort(abort_a),
    .tmr_done(tdone_a), .tmr_req(req_a), .stage_en(en_a), .busy(busy_a),
    .done(done_a), .err(err_a), .err_stage(estg_a), .frame_cnt(fcnt_a)
  );

  stage_sequencer #(.NUM_FRAMES(3), .GAP_CYCLES(2), .TIMEOUT(200)) dut_b (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start(start_b), .abort(abort_b),
    .tmr_done(tdone_b), .tmr_req(req_b), .stage_en(en_b), .busy(busy_b),
    .done(done_b), .err(err_b), .err_stage(estg_b), .frame_cnt(fcnt_b)
  );

  // Timer model: expires N cycles after its request rises, clears while request is low.
  int thr_a[4], thr_b[4], tc_a[4], tc_b[4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      tc_a[k] <= req_a[k] ? tc_a[k] + 1 : 0;
      tc_b[k] <= req_b[k] ? tc_b[k] + 1 : 0;
    end
  end

  always_comb begin
    tdone_a = stray_a;
    tdone_b = '0;
    for (int k = 0; k < 4; k++) begin
      if (req_a[k] && (tc_a[k] >= thr_a[k])) tdone_a[k] = 1'b1;
      if (req_b[k] && (tc_b[k] >= thr_b[k])) tdone_b[k] = 1'b1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int r0, r3, dn, dcyc, first, bsy, oh, mism, errc, rises, nfc, found;
  logic [3:0] prev_req;
  logic [7:0] prev_fcnt;
  int fc_hist[4];

  initial begin
    rst = 1'b1;
    start_a = 0; abort_a = 0; stray_a = '0;
    start_b = 0; abort_b = 0;
    thr_a = '{70, 31, 1, 1085};
    thr_b = '{5, 3, 1, 7};
    #1;
    check("rst_req_a", req_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_err_b", err_b, 0);
    check("rst_fcnt_b", fcnt_b, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frame on A with a stray tmr_done[2] in RUN_0 and a start pulse while busy.
    start_a = 1;
    r0 = 0; r3 = 0; dn = 0; dcyc = 0; oh = 0; mism = 0; first = 0; bsy = 0;
    for (int c = 1; c <= 1300; c++) begin
      @(negedge clk);
      if (c == 1) begin first = req_a; bsy = busy_a; end
      start_a = (c == 100);
      stray_a = (c >= 2 && c <= 30) ? 4'b0100 : 4'b0000;
      if (req_a == 4'b0001) r0++;
      if (req_a == 4'b1000) r3++;
      if (done_a) begin dn++; dcyc = c; end
      if ($countones(req_a) > 1) oh++;
      if (en_a !== req_a) mism++;
    end
    check("a_first_req", first, 1);
    check("a_busy_run", bsy, 1);
    check("a_run0_len", r0, 71);
    check("a_run3_len", r3, 1086);
    check("a_done_cnt", dn, 1);
    check("a_done_cyc", dcyc, 1196);
    check("a_fcnt", fcnt_a, 1);
    check("a_onehot", oh, 0);
    check("a_en_eq_req", mism, 0);
    check("a_idle_busy", busy_a, 0);

    // Async reset asserted mid RUN_2.
    start_a = 1;
    found = 0;
    for (int c = 1; c <= 300 && found == 0; c++) begin
      @(negedge clk);
      start_a = 0;
      if (req_a == 4'b0100) found = 1;
    end
    check("a_reach_run2", found, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", req_a, 0);
    check("arst_en", en_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_fcnt", fcnt_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_idle_req", req_a, 0);
    check("arst_idle_busy", busy_a, 0);

    // Abort during RUN_1.
    start_a = 1;
    found = 0;
    for (int c = 1; c <= 300 && found == 0; c++) begin
      @(negedge clk);
      start_a = 0;
      if (req_a == 4'b0010) found = 1;
    end
    check("a_reach_run1", found, 1);
    repeat (3) @(negedge clk);
    abort_a = 1;
    @(negedge clk);
    abort_a = 0;
    check("abort_req", req_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_fcnt", fcnt_a, 0);
    dn = 0; bsy = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done_a) dn++;
      if (busy_a) bsy++;
    end
    check("abort_no_done", dn, 0);
    check("abort_stays_idle", bsy, 0);
    start_a = 1; abort_a = 1;
    @(negedge clk);
    start_a = 0; abort_a = 0;
    check("abort_start_busy", busy_a, 0);
    @(negedge clk);
    check("abort_start_req", req_a, 0);

    // Multi-frame on B: frame = (6+2)+(4+2)+(2+2)+(8+2) = 28 cycles.
    start_b = 1;
    rises = 0; nfc = 0; dn = 0; dcyc = 0; oh = 0;
    prev_req = '0; prev_fcnt = fcnt_b;
    fc_hist = '{0, 0, 0, 0};
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      start_b = 0;
      if (req_b[0] && !prev_req[0]) rises++;
      if (fcnt_b != prev_fcnt && nfc < 4) begin fc_hist[nfc] = fcnt_b; nfc++; end
      if (done_b) begin dn++; dcyc = c; end
      if ($countones(req_b) > 1) oh++;
      prev_req = req_b; prev_fcnt = fcnt_b;
    end
    check("b_run0_rises", rises, 3);
    check("b_fcnt_steps", nfc, 3);
    check("b_fcnt_1", fc_hist[0], 1);
    check("b_fcnt_2", fc_hist[1], 2);
    check("b_fcnt_3", fc_hist[2], 3);
    check("b_done_cnt", dn, 1);
    check("b_done_cyc", dcyc, 85);
    check("b_onehot", oh, 0);

    // Watchdog: stage 3 never expires; RUN_3 starts at cycle 19 and lasts 200.
    thr_b[3] = 1000;
    start_b = 1;
    r3 = 0; errc = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start_b = 0;
      if (req_b == 4'b1000) r3++;
      if (err_b && errc == 0) errc = c;
    end
    check("wd_run3_len", r3, 200);
    check("wd_err_cyc", errc, 219);
    check("wd_err", err_b, 1);
    check("wd_err_stage", estg_b, 3);
    check("wd_busy", busy_b, 0);
    check("wd_req", req_b, 0);
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    check("wd_restart_err", err_b, 0);
    check("wd_restart_req", req_b, 1);
    check("wd_restart_busy", busy_b, 1);
    found = 0;
    for (int c = 1; c <= 300 && found == 0; c++) begin
      @(negedge clk);
      if (err_b) found = 1;
    end
    check("wd_err_again", found, 1);
    abort_b = 1;
    @(negedge clk);
    abort_b = 0;
    check("err_abort_err", err_b, 0);
    check("err_abort_stage", estg_b, 0);
    check("err_abort_busy", busy_b, 0);

    // tmr_done[3] on the watchdog terminal cycle: RUN_3 lasts 200 with no error.
    thr_b[3] = 199;
    start_b = 1;
    r3 = 0; errc = 0; dn = 0; dcyc = 0;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      start_b = 0;
      if (req_b == 4'b1000) r3++;
      if (err_b) errc++;
      if (done_b) begin dn++; dcyc = c; end
    end
    check("tc_run3_total", r3, 600);
    check("tc_no_err", errc, 0);
    check("tc_done_cnt", dn, 1);
    check("tc_done_cyc", dcyc, 661);
    check("tc_fcnt", fcnt_b, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
